reset_pulse_gen: RTL and testbench
==================================

// Module: reset_pulse_gen
// PURPOSE
//   Reset generator feeding the downstream async-reset flops (d_ff and friends): turns an async
//   request or a one-cycle software pulse into a clean, registered, min-width reset pulse.
//   Synchronizes the async request, stretches the pulse to HOLD_CYCLES, enforces a settle gap
//   before flagging ready, and counts reset events. Sits at the top level next to the clock source.
// PARAMETERS
//   SYNC_STAGES    2   flops in the req_async synchronizer (>=2)
//   HOLD_CYCLES    4   minimum rst_out high width in clk cycles (1..255)
//   RELEASE_DELAY  2   cycles from rst_out deassert to ready assert (1..255)
// PORTS
//   clk        in   1  system clock, all logic on posedge
//   reset      in   1  synchronous, active-low (0 = in reset), sampled on posedge clk
//   req_async  in   1  active-high reset request, asynchronous to clk
//   req_sw     in   1  active-high request, synchronous to clk, typically a 1-cycle pulse
//   rst_out    out  1  active-high reset to downstream flops, driven straight from a flop
//   busy       out  1  1 whenever FSM is not IDLE
//   ready      out  1  1 when downstream is out of reset and settled (FSM in IDLE)
//   event_cnt  out  8  request-triggered reset events since own reset, saturating
// BEHAVIOUR
//   - Own reset (reset==0 at an edge): state=HOLD, cnt=HOLD_CYCLES-1, rst_out=1, busy=1,
//     ready=0, event_cnt=0, sync flops=0. Power-on is not counted. Reset asserted mid-operation
//     restarts the full hold from any state.
//   - trig = req_s | req_sw, where req_s is req_async after SYNC_STAGES flops.
//   - All outputs are registered; every state change and output change happens on posedge clk.
//   - IDLE: rst_out=0, ready=1. If trig at edge N: go HOLD, rst_out=1, cnt=HOLD_CYCLES-1,
//     event_cnt+1 (saturate at 255).
//   - HOLD: rst_out=1. If cnt!=0: cnt-1. If cnt==0: go WAIT_REL when trig is still 1,
//     otherwise go SETTLE with rst_out=0 and cnt=RELEASE_DELAY-1. A trig arriving during HOLD
//     neither restarts the hold nor increments event_cnt.
//   - WAIT_REL: rst_out=1 while trig=1. On the first edge with trig=0: go SETTLE, rst_out=0,
//     cnt=RELEASE_DELAY-1.
//   - SETTLE: rst_out=0, ready=0. If trig: go HOLD, reload cnt=HOLD_CYCLES-1, event_cnt+1.
//     Else if cnt==0: go IDLE, ready=1. Else cnt-1.
//   - Latency: req_sw high at edge N gives rst_out=1 after edge N, through edge N+HOLD_CYCLES-1,
//     and rst_out=0 after edge N+HOLD_CYCLES. ready=1 after edge N+HOLD_CYCLES+RELEASE_DELAY.
//     For req_async, add SYNC_STAGES edges of synchronizer delay.
//   - rst_out never glitches. It has no combinational path from any input.
//   - The hold/settle counter is 8 bits wide and never wraps.
// STRUCTURE
//   - Package reset_pulse_gen_pkg holds: the state_t enum (IDLE, HOLD, WAIT_REL, SETTLE),
//     EVENT_CNT_W=8, and EVENT_CNT_MAX=8'hFF.
//   - Sub-module bit_sync (param STAGES) is the req_async synchronizer; its flops clear on
//     reset==0.
//   - The top level contains the FSM, the shared hold/settle counter and the saturating
//     event counter.
// TESTING (defaults: SYNC_STAGES=2, HOLD_CYCLES=4, RELEASE_DELAY=2; 10ns clock)
//   1 Power-on: reset=0 for 3 edges -> rst_out=1, busy=1, ready=0, event_cnt=0. After release,
//     rst_out stays 1 for 4 edges, then 0; ready=1 two edges later.
//   2 req_sw pulse at edge N (from IDLE) -> rst_out=1 after N..N+3, 0 after N+4; ready=1 after
//     N+6; event_cnt=1.
//   3 req_async rises between edges (clk low, just after an edge) and is held 10 cycles ->
//     rst_out rises 2 edges after first capture and stays 1 until 2 edges after req_async
//     falls; then SETTLE, ready after 2 more edges.
//   4 req_sw during SETTLE -> back to HOLD with a full 4-cycle pulse; ready stays 0;
//     event_cnt increments to 2.
//   5 reset=0 in mid-HOLD (cnt=1) -> event_cnt=0, full 4-cycle hold after release;
//     busy stays 1 throughout.
//   6 300 spaced req_sw pulses -> event_cnt stops at 255 and never wraps to 0.

Source files
------------

// File: rtl/reset_pulse_gen_pkg.sv
// Shared types and constants for the reset pulse generator.
// Holds the FSM state encoding and the event-counter width and limit.
package reset_pulse_gen_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOLD     = 2'd1,
    WAIT_REL = 2'd2,
    SETTLE   = 2'd3
  } state_t;

  localparam int                     EVENT_CNT_W   = 8;
  localparam logic [EVENT_CNT_W-1:0] EVENT_CNT_MAX = 8'hFF;

  // Increments the value but stops at EVENT_CNT_MAX instead of wrapping.
  function automatic logic [EVENT_CNT_W-1:0] sat_inc(input logic [EVENT_CNT_W-1:0] v);
    return (v == EVENT_CNT_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/reset_pulse_gen_bit_sync.sv
// Multi-flop synchronizer that brings a single asynchronous bit into the clk domain.
// All stages clear while the synchronous active-low reset is held.
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/reset_pulse_gen.sv
// Reset generator: turns an async or one-cycle software request into a registered,
// min-width reset pulse, then waits a settle gap before flagging downstream as ready.
module reset_pulse_gen
  import reset_pulse_gen_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int HOLD_CYCLES   = 4,
  parameter int RELEASE_DELAY = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_async,
  input  logic                   req_sw,
  output logic                   rst_out,
  output logic                   busy,
  output logic                   ready,
  output logic [EVENT_CNT_W-1:0] event_cnt
);

  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] REL_LOAD  = 8'(RELEASE_DELAY - 1);

  state_t                 state_q, state_d;
  logic [7:0]             cnt_q, cnt_d;
  logic                   rst_out_q, rst_out_d;
  logic                   busy_q, ready_q;
  logic [EVENT_CNT_W-1:0] event_cnt_q, event_cnt_d;
  logic                   req_s;
  logic                   trig;

  bit_sync #(
    .STAGES(SYNC_STAGES)
  ) u_req_sync (
    .clk_i (clk),
    .rst_ni(reset),
    .d_i   (req_async),
    .q_o   (req_s)
  );

  assign trig = req_s | req_sw;

  // One shared down-counter times both the hold width and the settle gap.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rst_out_d   = rst_out_q;
    event_cnt_d = event_cnt_q;
    unique case (state_q)
      IDLE: begin
        rst_out_d = 1'b0;
        if (trig) begin
          state_d     = HOLD;
          cnt_d       = HOLD_LOAD;
          rst_out_d   = 1'b1;
          event_cnt_d = sat_inc(event_cnt_q);
        end
      end
      HOLD: begin
        rst_out_d = 1'b1;
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else if (trig) begin
          state_d = WAIT_REL;
        end else begin
          state_d   = SETTLE;
          rst_out_d = 1'b0;
          cnt_d     = REL_LOAD;
        end
      end
      WAIT_REL: begin
        rst_out_d = 1'b1;
        if (!trig) begin
          state_d   = SETTLE;
          rst_out_d = 1'b0;
          cnt_d     = REL_LOAD;
        end
      end
      SETTLE: begin
        rst_out_d = 1'b0;
        if (trig) begin
          state_d     = HOLD;
          cnt_d       = HOLD_LOAD;
          rst_out_d   = 1'b1;
          event_cnt_d = sat_inc(event_cnt_q);
        end else if (cnt_q == 8'd0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d   = HOLD;
        cnt_d     = HOLD_LOAD;
        rst_out_d = 1'b1;
      end
    endcase
  end

  // busy/ready are registered from the next state so they change with the FSM.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= HOLD;
      cnt_q       <= HOLD_LOAD;
      rst_out_q   <= 1'b1;
      busy_q      <= 1'b1;
      ready_q     <= 1'b0;
      event_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rst_out_q   <= rst_out_d;
      busy_q      <= (state_d != IDLE);
      ready_q     <= (state_d == IDLE);
      event_cnt_q <= event_cnt_d;
    end
  end

  assign rst_out   = rst_out_q;
  assign busy      = busy_q;
  assign ready     = ready_q;
  assign event_cnt = event_cnt_q;

endmodule

// File: tb/tb_reset_pulse_gen.sv
// Scoreboard bench for reset_pulse_gen: directed steps queue hand-computed expectations,
// a monitor pops one record per checked cycle and compares it against the outputs.
module tb_reset_pulse_gen;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req_async = 1'b0;
  logic       req_sw = 1'b0;
  logic       rst_out;
  logic       busy;
  logic       ready;
  logic [7:0] event_cnt;

  typedef struct {
    logic  expRst;
    logic  expBusy;
    logic  expReady;
    int    expEvt;
    string name;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;

  reset_pulse_gen #(
    .SYNC_STAGES  (2),
    .HOLD_CYCLES  (4),
    .RELEASE_DELAY(2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_async(req_async),
    .req_sw   (req_sw),
    .rst_out  (rst_out),
    .busy     (busy),
    .ready    (ready),
    .event_cnt(event_cnt)
  );

  always #5 clk = ~clk;

  // Drives inputs on the falling edge; expected values describe outputs after the next rising edge.
  task automatic applyStimulus(input logic rstN, input logic a, input logic s, input bit chk,
                               input logic er, input logic eb, input logic erd, input int ee,
                               input string nm);
    exp_t e;
    @(negedge clk);
    reset     = rstN;
    req_async = a;
    req_sw    = s;
    if (chk) begin
      e.expRst   = er;
      e.expBusy  = eb;
      e.expReady = erd;
      e.expEvt   = ee;
      e.name     = nm;
      expQ.push_back(e);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    checks += 4;
    if (rst_out !== e.expRst) begin
      errors++;
      $display("[TB] FAIL %s.rst_out got %b expected %b", e.name, rst_out, e.expRst);
    end
    if (busy !== e.expBusy) begin
      errors++;
      $display("[TB] FAIL %s.busy got %b expected %b", e.name, busy, e.expBusy);
    end
    if (ready !== e.expReady) begin
      errors++;
      $display("[TB] FAIL %s.ready got %b expected %b", e.name, ready, e.expReady);
    end
    if (event_cnt !== 8'(e.expEvt)) begin
      errors++;
      $display("[TB] FAIL %s.event_cnt got %0d expected %0d", e.name, event_cnt, e.expEvt);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() != 0) begin
        e = expQ.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    int expEvt;
    // Power-on reset held for three edges, then the default 4-cycle hold and 2-cycle settle.
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1, 1, 1, 0, 0, "por_in_reset");
    applyStimulus(1, 0, 0, 1, 1, 1, 0, 0, "por_e1");
    applyStimulus(1, 0, 0, 1, 1, 1, 0, 0, "por_e2");
    applyStimulus(1, 0, 0, 1, 1, 1, 0, 0, "por_e3");
    applyStimulus(1, 0, 0, 1, 0, 1, 0, 0, "por_e4_release");
    applyStimulus(1, 0, 0, 1, 0, 1, 0, 0, "por_e5_settle");
    applyStimulus(1, 0, 0, 1, 0, 0, 1, 0, "por_e6_ready");
    applyStimulus(1, 0, 0, 1, 0, 0, 1, 0, "por_idle");

    // Software pulse from IDLE.
    applyStimulus(1, 0, 1, 1, 1, 1, 0, 1, "sw_n");
    applyStimulus(1, 0, 0, 1, 1, 1, 0, 1, "sw_n1");
    applyStimulus(1, 0, 0, 1, 1, 1, 0, 1, "sw_n2");
    applyStimulus(1, 0, 0, 1, 1, 1, 0, 1, "sw_n3");
    applyStimulus(1, 0, 0, 1, 0, 1, 0, 1, "sw_n4_release");
    applyStimulus(1, 0, 0, 1, 0, 1, 0, 1, "sw_n5_settle");
    applyStimulus(1, 0, 0, 1, 0, 0, 1, 1, "sw_n6_ready");
    applyStimulus(1, 0, 0, 1, 0, 0, 1, 1, "sw_idle");

    // Async request held for ten edges: two-edge sync delay, WAIT_REL stretch, two-edge tail.
    applyStimulus(1, 1, 0, 1, 0, 0, 1, 1, "async_a0");
    applyStimulus(1, 1, 0, 1, 0, 0, 1, 1, "async_a1");
    for (int i = 0; i < 8; i++) applyStimulus(1, 1, 0, 1, 1, 1, 0, 2, "async_held");
    applyStimulus(1, 0, 0, 1, 1, 1, 0, 2, "async_a10_tail");
    applyStimulus(1, 0, 0, 1, 1, 1, 0, 2, "async_a11_tail");
    applyStimulus(1, 0, 0, 1, 0, 1, 0, 2, "async_a12_release");
    applyStimulus(1, 0, 0, 1, 0, 1, 0, 2, "async_a13_settle");
    applyStimulus(1, 0, 0, 1, 0, 0, 1, 2, "async_a14_ready");

    // Request during SETTLE restarts a full hold and counts as a new event.
    applyStimulus(1, 0, 1, 1, 1, 1, 0, 3, "settle_s0");
    applyStimulus(1, 0, 0, 1, 1, 1, 0, 3, "settle_s1");
    applyStimulus(1, 0, 0, 1, 1, 1, 0, 3, "settle_s2");
    applyStimulus(1, 0, 0, 1, 1, 1, 0, 3, "settle_s3");
    applyStimulus(1, 0, 0, 1, 0, 1, 0, 3, "settle_s4_in_settle");
    applyStimulus(1, 0, 1, 1, 1, 1, 0, 4, "settle_s5_retrig");
    applyStimulus(1, 0, 0, 1, 1, 1, 0, 4, "settle_s6");
    applyStimulus(1, 0, 0, 1, 1, 1, 0, 4, "settle_s7");
    applyStimulus(1, 0, 0, 1, 1, 1, 0, 4, "settle_s8");
    applyStimulus(1, 0, 0, 1, 0, 1, 0, 4, "settle_s9_release");
    applyStimulus(1, 0, 0, 1, 0, 1, 0, 4, "settle_s10");
    applyStimulus(1, 0, 0, 1, 0, 0, 1, 4, "settle_s11_ready");

    // Own reset in mid-HOLD clears the event count and restarts the full hold.
    applyStimulus(1, 0, 1, 1, 1, 1, 0, 5, "midrst_t0");
    applyStimulus(1, 0, 0, 1, 1, 1, 0, 5, "midrst_t1");
    applyStimulus(1, 0, 0, 1, 1, 1, 0, 5, "midrst_t2");
    applyStimulus(0, 0, 0, 1, 1, 1, 0, 0, "midrst_assert");
    applyStimulus(1, 0, 0, 1, 1, 1, 0, 0, "midrst_r1");
    applyStimulus(1, 0, 0, 1, 1, 1, 0, 0, "midrst_r2");
    applyStimulus(1, 0, 0, 1, 1, 1, 0, 0, "midrst_r3");
    applyStimulus(1, 0, 0, 1, 0, 1, 0, 0, "midrst_r4_release");
    applyStimulus(1, 0, 0, 1, 0, 1, 0, 0, "midrst_r5");
    applyStimulus(1, 0, 0, 1, 0, 0, 1, 0, "midrst_r6_ready");

    // 300 spaced pulses: the event count saturates at 255.
    for (int i = 0; i < 300; i++) begin
      expEvt = (i + 1 > 255) ? 255 : i + 1;
      applyStimulus(1, 0, 1, 1, 1, 1, 0, expEvt, "sat_pulse");
      for (int j = 0; j < 5; j++) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, "");
      applyStimulus(1, 0, 0, 1, 0, 0, 1, expEvt, "sat_ready");
    end

    repeat (3) @(negedge clk);
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain pending %0d expected %0d", expQ.size(), 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
